// File: rtl/led_mode_controller.sv
// led_mode_controller
//   Steps the LED through four display modes (OFF, ON, BLINK_SLOW, BLINK_FAST).
//   The LED is driven by one active-low push switch. The raw switch is synchronised
//   and debounced. Each debounced release advances the mode. The blink timing for
//   the two blink modes is generated here.
//
// Parameters
//   DEBOUNCE_CYCLES   : consecutive mismatched cycles before the debounced state flips (>=2)
//   SLOW_HALF_PERIOD  : cycles per LED phase in BLINK_SLOW (>=1)
//   FAST_HALF_PERIOD  : cycles per LED phase in BLINK_FAST (>=1)
//   LONG_PRESS_CYCLES : held-press length that forces OFF (used only with LED_LONG_PRESS_EN)
//
// Ports
//   i_Clk      : system clock, rising edge
//   i_Rst      : asynchronous reset, active-high
//   i_Switch_1 : raw switch, 1 = released, 0 = pressed (asynchronous, bouncy)
//   o_LED_1    : LED drive, 1 = on (registered)
//   o_Mode     : current mode, 0 OFF / 1 ON / 2 BLINK_SLOW / 3 BLINK_FAST
//   o_Release  : one-cycle pulse on each accepted debounced release
//
// Build option
//   LED_LONG_PRESS_EN : when defined, a press held for LONG_PRESS_CYCLES forces OFF, and
//                       the release that ends that hold is swallowed.
//                       When undefined, a hold of any length is one normal press.

module led_mode_controller #(
   parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
   parameter int unsigned SLOW_HALF_PERIOD  = 12_500_000,
   parameter int unsigned FAST_HALF_PERIOD  = 2_500_000,
   parameter int unsigned LONG_PRESS_CYCLES = 50_000_000
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Switch_1,
   output logic       o_LED_1,
   output logic [1:0] o_Mode,
   output logic       o_Release
);

   typedef enum logic [1:0] {
      ModeOff       = 2'd0,
      ModeOn        = 2'd1,
      ModeBlinkSlow = 2'd2,
      ModeBlinkFast = 2'd3
   } mode_e;

   localparam int unsigned DebW    = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned MaxHalf = (SLOW_HALF_PERIOD > FAST_HALF_PERIOD) ?
                                     SLOW_HALF_PERIOD : FAST_HALF_PERIOD;
   localparam int unsigned BlinkW  = $clog2(MaxHalf + 1);

   localparam logic [DebW-1:0]   DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BlinkW-1:0] SlowLast = BlinkW'(SLOW_HALF_PERIOD - 1);
   localparam logic [BlinkW-1:0] FastLast = BlinkW'(FAST_HALF_PERIOD - 1);

   logic              sync1_q, sync2_q;
   logic              deb_q, deb_d;
   logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic [BlinkW-1:0] half_last;
   logic              phase_q, phase_d;
   mode_e             mode_q, mode_d;
   logic              led_q, led_d;
   logic              release_q, release_d;
   logic              rise;
   logic              advance;
   logic              force_off;

   // Debounce: flip only after DEBOUNCE_CYCLES consecutive mismatched edges.
   // Any matching edge restarts the count.
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (deb_cnt_q == DebLast) begin
            deb_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   assign rise = ~deb_q & deb_d;

`ifdef LED_LONG_PRESS_EN
   localparam int unsigned LpW    = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [LpW-1:0] LpLast = LpW'(LONG_PRESS_CYCLES - 1);

   logic [LpW-1:0] lp_cnt_q, lp_cnt_d;
   logic           suppress_q, suppress_d;

   // suppress_q doubles as "already fired this hold". The counter freezes once
   // the long press has fired, so the long press fires only once per hold.
   always_comb begin
      lp_cnt_d   = lp_cnt_q;
      suppress_d = suppress_q;
      force_off  = 1'b0;
      advance    = 1'b0;
      if (rise) begin
         lp_cnt_d   = '0;
         suppress_d = 1'b0;
         advance    = ~suppress_q;
      end else if (deb_q) begin
         lp_cnt_d = '0;
      end else if (!suppress_q) begin
         if (lp_cnt_q == LpLast) begin
            force_off  = 1'b1;
            suppress_d = 1'b1;
            lp_cnt_d   = '0;
         end else begin
            lp_cnt_d = lp_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         lp_cnt_q   <= '0;
         suppress_q <= 1'b0;
      end else begin
         lp_cnt_q   <= lp_cnt_d;
         suppress_q <= suppress_d;
      end
   end
`else
   always_comb begin
      advance   = rise;
      force_off = 1'b0;
   end
`endif

   // Mode sequencing and blink engine.
   // Any mode change restarts the blink with the LED off.
   always_comb begin
      mode_d      = mode_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      half_last   = (mode_q == ModeBlinkSlow) ? SlowLast : FastLast;
      if (force_off) begin
         mode_d      = ModeOff;
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (advance) begin
         mode_d      = mode_e'(mode_q + 2'd1);
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (mode_q == ModeBlinkSlow || mode_q == ModeBlinkFast) begin
         if (blink_cnt_q == half_last) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      led_d = 1'b0;
      unique case (mode_d)
         ModeOff:       led_d = 1'b0;
         ModeOn:        led_d = 1'b1;
         ModeBlinkSlow: led_d = phase_d;
         ModeBlinkFast: led_d = phase_d;
         default:       led_d = 1'b0;
      endcase
      release_d = advance;
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         deb_q       <= 1'b1;
         deb_cnt_q   <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         mode_q      <= ModeOff;
         led_q       <= 1'b0;
         release_q   <= 1'b0;
      end else begin
         sync1_q     <= i_Switch_1;
         sync2_q     <= sync1_q;
         deb_q       <= deb_d;
         deb_cnt_q   <= deb_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         mode_q      <= mode_d;
         led_q       <= led_d;
         release_q   <= release_d;
      end
   end

   assign o_LED_1   = led_q;
   assign o_Mode    = mode_q;
   assign o_Release = release_q;

endmodule

// File: tb/tb_led_mode_controller.sv
// Testbench for led_mode_controller: directed scenarios plus randomized switch activity,
// all checked cycle by cycle against a behavioural model.

module tb_led_mode_controller;

   localparam int unsigned D    = 4;
   localparam int unsigned SLOW = 8;
   localparam int unsigned FAST = 2;
   localparam int unsigned LP   = 20;

   logic       clk;
   logic       rst;
   logic       sw;
   logic       led;
   logic [1:0] mode;
   logic       rel;

   int n_checks;
   int n_fail;
   int rel_seen;

   led_mode_controller #(
      .DEBOUNCE_CYCLES   (D),
      .SLOW_HALF_PERIOD  (SLOW),
      .FAST_HALF_PERIOD  (FAST),
      .LONG_PRESS_CYCLES (LP)
   ) dut (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .i_Switch_1 (sw),
      .o_LED_1    (led),
      .o_Mode     (mode),
      .o_Release  (rel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: the debounced level flips once the last D synchronised samples
   // all disagree with it. The blink phase is derived from the cycles elapsed since
   // the mode was entered.
   logic       m_s1, m_s2, m_deb;
   bit         win[$];
   int         m_mode;
   int         m_since;
   int         m_held;
   bit         m_sup;
   logic       m_rel;

   function automatic void m_reset();
      m_s1    = 1'b1;
      m_s2    = 1'b1;
      m_deb   = 1'b1;
      win.delete();
      m_mode  = 0;
      m_since = 0;
      m_held  = 0;
      m_sup   = 1'b0;
      m_rel   = 1'b0;
   endfunction

   function automatic logic m_led();
      case (m_mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return logic'((m_since / SLOW) % 2);
         default: return logic'((m_since / FAST) % 2);
      endcase
   endfunction

   function automatic void m_step();
      bit   all_diff, rise, adv, fire;
      logic pre_deb;
      if (rst) begin
         m_reset();
         return;
      end
      rise  = 1'b0;
      adv   = 1'b0;
      fire  = 1'b0;
      m_rel = 1'b0;
      win.push_back(m_s2);
      if (win.size() > D) void'(win.pop_front());
      all_diff = (win.size() == D);
      foreach (win[i]) if (win[i] == m_deb) all_diff = 1'b0;
      pre_deb = m_deb;
      if (all_diff) begin
         m_deb = ~m_deb;
         rise  = m_deb;
      end
`ifdef LED_LONG_PRESS_EN
      if (rise) begin
         m_held = 0;
         adv    = !m_sup;
         m_sup  = 1'b0;
      end else if (pre_deb == 1'b0) begin
         m_held++;
         if (m_held == LP && !m_sup) begin
            fire  = 1'b1;
            m_sup = 1'b1;
         end
      end else begin
         m_held = 0;
      end
`else
      adv = rise;
`endif
      if (fire) begin
         m_mode  = 0;
         m_since = 0;
      end else if (adv) begin
         m_mode  = (m_mode + 1) % 4;
         m_since = 0;
         m_rel   = 1'b1;
      end else begin
         m_since++;
      end
      m_s2 = m_s1;
      m_s1 = sw;
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         m_step();
         #1;
         check("mode", 32'(mode), 32'(m_mode));
         check("led", 32'(led), 32'(m_led()));
         check("release", 32'(rel), 32'(m_rel));
         if (rel === 1'b1) rel_seen++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_reset();
      #1;
      check("rst_async_mode", 32'(mode), 32'd0);
      check("rst_async_led", 32'(led), 32'd0);
      tick(3);
      rst = 1'b0;
   endtask

   task automatic press_release(input int low, input int high);
      sw = 1'b0;
      tick(low);
      sw = 1'b1;
      tick(high);
   endtask

   // Wait up to a bound for o_Mode to reach a value; return ticks taken, -1 on timeout.
   task automatic wait_mode(input logic [1:0] want, output int taken);
      taken = -1;
      for (int i = 1; i <= 30; i++) begin
         tick(1);
         if (mode == want) begin
            taken = i;
            break;
         end
      end
   endtask

   initial begin
      int   taken, toggles, start_rel, start_mode;
      logic prev;
      n_checks = 0;
      n_fail   = 0;
      rel_seen = 0;
      sw       = 1'b1;
      rst      = 1'b0;
      m_reset();
      #2;

      // 1. Reset
      do_reset();
      tick(2);
      check("t1_mode", 32'(mode), 32'd0);
      check("t1_release", 32'(rel), 32'd0);

      // 2. Clean press, then release: mode 0->1 on the 6th edge after the release
      sw = 1'b0;
      tick(20);
      start_rel = rel_seen;
      sw = 1'b1;
      wait_mode(2'd1, taken);
      check("t2_latency", 32'(taken), 32'd6);
      check("t2_led", 32'(led), 32'd1);
      tick(5);
      check("t2_pulses", 32'(rel_seen - start_rel), 32'd1);

      // 3. Bounce: low 10, toggle every 2 cycles for 12, then high and hold
      start_rel  = rel_seen;
      start_mode = int'(mode);
      sw = 1'b0;
      tick(10);
      for (int i = 0; i < 6; i++) begin
         sw = ~sw;
         tick(2);
      end
      sw = 1'b1;
      tick(20);
      check("t3_pulses", 32'(rel_seen - start_rel), 32'd1);
      check("t3_mode", 32'(mode), 32'((start_mode + 1) % 4));

      // 4. Four clean press/release pairs from reset
      do_reset();
      tick(2);
      for (int i = 1; i <= 4; i++) begin
         press_release(10, 12);
         check("t4_mode", 32'(mode), 32'(i % 4));
      end
      check("t4_led_end", 32'(led), 32'd0);

      // 5. Blinking: slow, then fast; each starts with the LED off
      press_release(10, 12);
      sw = 1'b0;
      tick(10);
      sw = 1'b1;
      wait_mode(2'd2, taken);
      check("t5_slow_enter_led", 32'(led), 32'd0);
      toggles = 0;
      prev    = led;
      for (int i = 0; i < 32; i++) begin
         tick(1);
         if (led != prev) toggles++;
         prev = led;
      end
      check("t5_slow_toggles", 32'(toggles), 32'd4);
      sw = 1'b0;
      tick(10);
      sw = 1'b1;
      wait_mode(2'd3, taken);
      check("t5_fast_enter_led", 32'(led), 32'd0);
      toggles = 0;
      prev    = led;
      for (int i = 0; i < 16; i++) begin
         tick(1);
         if (led != prev) toggles++;
         prev = led;
      end
      check("t5_fast_toggles", 32'(toggles), 32'd8);

      // 6. Long hold in mode 2
      do_reset();
      tick(2);
      press_release(10, 12);
      press_release(10, 12);
      check("t6_mode_before", 32'(mode), 32'd2);
      start_rel = rel_seen;
      sw = 1'b0;
      tick(40);
`ifdef LED_LONG_PRESS_EN
      check("t6_mode_held", 32'(mode), 32'd0);
`else
      check("t6_mode_held", 32'(mode), 32'd2);
`endif
      sw = 1'b1;
      tick(15);
`ifdef LED_LONG_PRESS_EN
      check("t6_pulses", 32'(rel_seen - start_rel), 32'd0);
      check("t6_mode_after", 32'(mode), 32'd0);
`else
      check("t6_pulses", 32'(rel_seen - start_rel), 32'd1);
      check("t6_mode_after", 32'(mode), 32'd3);
`endif

      // Randomized switch activity, with one asynchronous mid-run reset
      for (int i = 0; i < 60; i++) begin
         if (i == 30) begin
            @(negedge clk);
            do_reset();
         end
         sw = ~sw;
         tick(int'($urandom_range(1, 26)));
      end
      sw = 1'b1;
      tick(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
